// File: rtl/sha256_compress_pipe_if.sv
// Block-in / digest-out handshake bundle for sha256_compress_pipe.
// mode_224 is present only when SHA256_COMPRESS_SHA224_EN is defined.
interface sha256_compress_pipe_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] dig_data;
  logic         busy;
`ifdef SHA256_COMPRESS_SHA224_EN
  logic         mode_224;

  modport master (
    output blk_valid, blk_data, blk_first, blk_last, dig_ready, mode_224,
    input  blk_ready, dig_valid, dig_data, busy
  );
  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, dig_ready, mode_224,
    output blk_ready, dig_valid, dig_data, busy
  );
`else
  modport master (
    output blk_valid, blk_data, blk_first, blk_last, dig_ready,
    input  blk_ready, dig_valid, dig_data, busy
  );
  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, dig_ready,
    output blk_ready, dig_valid, dig_data, busy
  );
`endif
endinterface

// File: rtl/sha256_compress_pipe.sv
// Iterative SHA-256 compression core, ROUNDS_PER_CYCLE rounds per clock, message schedule on the fly.
// Define SHA256_COMPRESS_SHA224_EN to add the mode_224 input (SHA-224 IVs and truncated digest).
module sha256_compress_pipe #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit OUT_HOLD         = 1
) (
  input logic                   clk,
  input logic                   rst,
  sha256_compress_pipe_if.slave bus
);
  localparam int         R        = ROUNDS_PER_CYCLE;
  localparam logic [6:0] CNT_STEP = 7'(ROUNDS_PER_CYCLE);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Element 0 (H0 / a) is the rightmost word of each packed constant.
  localparam logic [7:0][31:0] IV_256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

  state_t            state_reg, state_next;
  logic [7:0][31:0]  chain_reg;
  logic [7:0][31:0]  work_reg, work_next;
  logic [15:0][31:0] win_reg, win_next, blk_words;
  logic [6:0]        cnt_reg;
  logic              last_reg;
  logic [7:0][31:0]  iv_sel;
  logic [255:0]      digest;
  logic [31:0]       ext [16+R];
  logic [7:0][31:0]  round_st;
  logic [5:0]        k_idx;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s,
                                                 input logic [31:0] k, input logic [31:0] w);
    logic [31:0]      t1, t2;
    logic [7:0][31:0] r;
    t1   = s[7] + big_s1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2   = big_s0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r    = {s[6:0], t1 + t2};
    r[4] = s[3] + t1;
    return r;
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_blk_words
    assign blk_words[gi] = bus.blk_data[511-32*gi -: 32];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_digest
    assign digest[255-32*gi -: 32] = chain_reg[gi];
  end

`ifdef SHA256_COMPRESS_SHA224_EN
  localparam logic [7:0][31:0] IV_224 = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };
  logic mode_reg;

  assign iv_sel = bus.mode_224 ? IV_224 : IV_256;
  assign bus.dig_data = (state_reg != S_OUT) ? 256'h0 :
                        mode_reg ? {digest[255:32], 32'h0} : digest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mode_reg <= 1'b0;
    else if (state_reg == S_IDLE && bus.blk_valid && bus.blk_first)
      mode_reg <= bus.mode_224;
  end
`else
  assign iv_sel = IV_256;
  assign bus.dig_data = (state_reg == S_OUT) ? digest : 256'h0;
`endif

  assign bus.blk_ready = (state_reg == S_IDLE);
  assign bus.dig_valid = (state_reg == S_OUT);
  assign bus.busy      = (state_reg != S_IDLE);

  // ext[0..15] is the live window W[t..t+15]; ext[16..] extends it by R freshly scheduled words.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win_reg[i];
    for (int j = 0; j < R; j++)
      ext[16+j] = small_s1(ext[14+j]) + ext[9+j] + small_s0(ext[1+j]) + ext[j];
    round_st = work_reg;
    k_idx    = cnt_reg[5:0];
    for (int j = 0; j < R; j++) begin
      k_idx    = cnt_reg[5:0] + 6'(j);
      round_st = sha_round(round_st, K[k_idx], ext[j]);
    end
    work_next = round_st;
    for (int i = 0; i < 16; i++) win_next[i] = ext[i+R];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.blk_valid) state_next = S_ROUND;
      S_ROUND: if (cnt_reg + CNT_STEP >= 7'd64) state_next = S_FINAL;
      S_FINAL: state_next = last_reg ? S_OUT : S_IDLE;
      S_OUT:   if (!OUT_HOLD || bus.dig_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= IV_256;
      work_reg  <= '0;
      win_reg   <= '0;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (bus.blk_valid) begin
          win_reg  <= blk_words;
          last_reg <= bus.blk_last;
          cnt_reg  <= '0;
          // A first block restarts the chain so FINAL adds onto the IVs.
          if (bus.blk_first) begin
            chain_reg <= iv_sel;
            work_reg  <= iv_sel;
          end else begin
            work_reg  <= chain_reg;
          end
        end
        S_ROUND: begin
          work_reg <= work_next;
          win_reg  <= win_next;
          cnt_reg  <= (cnt_reg >= 7'd64) ? cnt_reg : cnt_reg + CNT_STEP;
        end
        S_FINAL: for (int i = 0; i < 8; i++) chain_reg[i] <= chain_reg[i] + work_reg[i];
        default: ;
      endcase
    end
  end
endmodule
